// File: rtl/smart_home_sensor_frontend.sv
// Sensor front end for the smart-home controller: debounced door/window/fire
// contacts plus a polled 3-wire serial temperature reader with parity check.
module smart_home_sensor_frontend #(
  parameter int                DEB_CYCLES = 4,
  parameter int                TEMP_W     = 7,
  parameter int                SCLK_HALF  = 2,
  parameter int                TEMP_POLL  = 64,
  parameter logic [TEMP_W-1:0] ST_RST     = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              raw_fd,
  input  logic              raw_rd,
  input  logic              raw_w,
  input  logic              raw_fa,
  input  logic              ts_sdo,
  output logic              ts_cs_n,
  output logic              ts_sclk,
  output logic              SFD,
  output logic              SRD,
  output logic              SW,
  output logic              SFA,
  output logic [TEMP_W-1:0] ST,
  output logic              st_valid,
  output logic              st_err
);

  localparam int NCH = 4;
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int FW  = TEMP_W + 2;
  localparam int BW  = $clog2(FW);
  localparam int PW  = $clog2(TEMP_POLL);
  localparam int HW  = $clog2(SCLK_HALF + 1);

  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, CHECK} state_t;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] deb;

  assign raw = {raw_fa, raw_w, raw_rd, raw_fd};

  // NOTE: non-blocking so the second stage takes the first stage's pre-edge
  // value; blocking assignments would collapse the synchroniser to one flop.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_deb
    logic [DCW-1:0] cnt;
    logic           q;

    // Any return to the current output level restarts the stability count.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        cnt <= '0;
        q   <= 1'b0;
      end else if (sync2[i] == q) begin
        cnt <= '0;
      end else if (cnt == DCW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        q   <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i] = q;
  end

  assign SFD = deb[0];
  assign SRD = deb[1];
  assign SW  = deb[2];
  assign SFA = deb[3];

  state_t         state;
  logic [PW-1:0]  poll_cnt;
  logic [HW-1:0]  half_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [FW-1:0]  shreg;
  logic           frame_good;

  // Frame layout in shreg once all bits are in: start, data MSB..LSB, parity.
  assign frame_good = ~shreg[FW-1] & ~(^shreg[FW-2:0]);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      poll_cnt <= '0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ts_cs_n  <= 1'b1;
      ts_sclk  <= 1'b0;
      ST       <= ST_RST;
      st_valid <= 1'b0;
      st_err   <= 1'b0;
    end else begin
      st_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (poll_cnt == PW'(TEMP_POLL - 1)) begin
            poll_cnt <= '0;
            half_cnt <= '0;
            ts_cs_n  <= 1'b0;
            state    <= SELECT;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        SELECT: begin
          if (half_cnt == HW'(SCLK_HALF - 1)) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (half_cnt != HW'(SCLK_HALF - 1)) begin
            half_cnt <= half_cnt + 1'b1;
          end else begin
            half_cnt <= '0;
            if (!ts_sclk) begin
              // A high start bit means no sensor answered: abandon the frame
              // without ever raising sclk.
              if (bit_cnt == '0 && ts_sdo) begin
                ts_cs_n <= 1'b1;
                st_err  <= 1'b1;
                state   <= CHECK;
              end else begin
                ts_sclk <= 1'b1;
                shreg   <= {shreg[FW-2:0], ts_sdo};
              end
            end else begin
              ts_sclk <= 1'b0;
              if (bit_cnt == BW'(FW - 1)) begin
                // ST and its strobe land together, so CHECK shows the new word.
                ts_cs_n <= 1'b1;
                state   <= CHECK;
                if (frame_good) begin
                  ST       <= shreg[FW-2:1];
                  st_valid <= 1'b1;
                  st_err   <= 1'b0;
                end else begin
                  st_err   <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        CHECK: begin
          poll_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smart_home_sensor_frontend.sv
// Directed bench for smart_home_sensor_frontend: serial sensor model, ST
// scoreboard fed at stimulus time, debounce latency and glitch checks.
module tb_smart_home_sensor_frontend;

  localparam int TEMP_W = 7;
  localparam int FW     = TEMP_W + 2;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              raw_fd = 1'b0;
  logic              raw_rd = 1'b0;
  logic              raw_w  = 1'b0;
  logic              raw_fa = 1'b0;
  logic              ts_sdo = 1'b0;
  logic              ts_cs_n;
  logic              ts_sclk;
  logic              SFD;
  logic              SRD;
  logic              SW;
  logic              SFA;
  logic [TEMP_W-1:0] ST;
  logic              st_valid;
  logic              st_err;

  smart_home_sensor_frontend dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .raw_fd   (raw_fd),
    .raw_rd   (raw_rd),
    .raw_w    (raw_w),
    .raw_fa   (raw_fa),
    .ts_sdo   (ts_sdo),
    .ts_cs_n  (ts_cs_n),
    .ts_sclk  (ts_sclk),
    .SFD      (SFD),
    .SRD      (SRD),
    .SW       (SW),
    .SFA      (SFA),
    .ST       (ST),
    .st_valid (st_valid),
    .st_err   (st_err)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [TEMP_W-1:0] exp_q[$];
  logic [FW-1:0]     tx_frame = '0;
  int                tx_idx = 0;
  int                cyc = 0;
  int                sclk_rises = 0;
  int                rise_cyc = 0;
  int                prev_rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Sensor: start bit on select, next bit after each falling sclk.
  always @(negedge ts_cs_n) begin
    tx_idx = 0;
    ts_sdo = tx_frame[FW-1];
  end

  always @(negedge ts_sclk) begin
    if (ts_cs_n === 1'b0) begin
      tx_idx++;
      if (tx_idx < FW) ts_sdo = tx_frame[FW-1-tx_idx];
    end
  end

  always @(posedge ts_cs_n) ts_sdo = 1'b0;

  always @(posedge Clk) cyc++;

  always @(posedge ts_sclk) begin
    sclk_rises++;
    prev_rise_cyc = rise_cyc;
    rise_cyc      = cyc;
  end

  // Scoreboard: every ST strobe must match the oldest expected word.
  always @(negedge Clk) begin
    if (Rst && st_valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_valid", 1, 0);
      else                   check("sb_st", ST, exp_q.pop_front());
    end
  end

  task automatic wait_cs_fall(output int n);
    n = 0;
    while (ts_cs_n !== 1'b0 && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    check("cs_fell", ts_cs_n, 0);
  endtask

  task automatic wait_cs_rise(output int n);
    n = 0;
    while (ts_cs_n !== 1'b1 && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    check("cs_rose", ts_cs_n, 1);
  endtask

  task automatic run_frame(input logic [FW-1:0] frame, input bit good,
                           output int gap, output int low,
                           output logic valid_end, output logic valid_next);
    tx_frame = frame;
    if (good) exp_q.push_back(frame[FW-2:1]);
    wait_cs_fall(gap);
    sclk_rises = 0;
    wait_cs_rise(low);
    valid_end = st_valid;
    @(posedge Clk); #1;
    valid_next = st_valid;
  endtask

  task automatic deb_latency(input int ch, input logic level, output int n);
    logic [3:0] outs;
    n = 0;
    outs = {SFA, SW, SRD, SFD};
    while (outs[ch] !== level && n < 20) begin
      @(posedge Clk); #1;
      n++;
      outs = {SFA, SW, SRD, SFD};
    end
  endtask

  initial begin
    int   gap;
    int   low;
    int   n;
    logic ve;
    logic vn;
    logic seen;

    #1 Rst = 1'b0;
    @(negedge Clk);
    check("rst_sfd", SFD, 0);
    check("rst_srd", SRD, 0);
    check("rst_sw", SW, 0);
    check("rst_sfa", SFA, 0);
    check("rst_st", ST, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_st_err", st_err, 0);
    check("rst_cs_n", ts_cs_n, 1);
    check("rst_sclk", ts_sclk, 0);

    // All-zero frame is good.
    @(negedge Clk);
    Rst = 1'b1;
    run_frame(9'b0_0000000_0, 1'b1, gap, low, ve, vn);
    check("first_conv_delay", gap, 64);
    check("frame_len", low, 38);
    check("sclk_periods", sclk_rises, 9);
    check("zero_valid_in_check", ve, 1);
    check("zero_valid_one_cycle", vn, 0);
    check("zero_st", ST, 0);
    check("zero_err", st_err, 0);

    // Debounce: clean edges on fd and fa together, short glitch on rd.
    @(negedge Clk);
    raw_fd = 1'b1;
    raw_fa = 1'b1;
    deb_latency(0, 1'b1, n);
    check("fd_rise_latency", n, 6);
    check("fa_independent", SFA, 1);
    check("sw_untouched", SW, 0);
    @(negedge Clk);
    raw_rd = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    raw_rd = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (SRD !== 1'b0) seen = 1'b1;
    end
    check("rd_glitch_filtered", seen, 0);
    @(negedge Clk);
    raw_fd = 1'b0;
    deb_latency(0, 1'b0, n);
    check("fd_fall_latency", n, 6);
    check("fa_holds", SFA, 1);

    // 23 = 0010111, four ones, parity 0.
    run_frame({1'b0, 7'd23, 1'b0}, 1'b1, gap, low, ve, vn);
    check("sclk_period", rise_cyc - prev_rise_cyc, 4);
    check("d23_sclk_periods", sclk_rises, 9);
    check("d23_valid_in_check", ve, 1);
    check("d23_valid_one_cycle", vn, 0);
    check("d23_st", ST, 23);
    check("d23_err", st_err, 0);

    // Same data, wrong parity.
    run_frame({1'b0, 7'd23, 1'b1}, 1'b0, gap, low, ve, vn);
    check("poll_gap", gap, 64);
    check("badpar_no_valid", ve, 0);
    check("badpar_err", st_err, 1);
    check("badpar_st_holds", ST, 23);

    // 30 = 0011110, four ones, parity 0; clears the error.
    run_frame({1'b0, 7'd30, 1'b0}, 1'b1, gap, low, ve, vn);
    check("d30_valid", ve, 1);
    check("d30_err_cleared", st_err, 0);
    check("d30_st", ST, 30);

    // Start bit high: abandoned after select plus one low half-period.
    run_frame({1'b1, 7'd5, 1'b0}, 1'b0, gap, low, ve, vn);
    check("abort_len", low, 4);
    check("abort_no_sclk", sclk_rises, 0);
    check("abort_no_valid", ve, 0);
    check("abort_err", st_err, 1);
    check("abort_st_holds", ST, 30);

    // Reset while bit 4 is being clocked.
    tx_frame = {1'b0, 7'd99, 1'b0};
    wait_cs_fall(n);
    sclk_rises = 0;
    n = 0;
    while (sclk_rises < 5 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check("reached_bit4", sclk_rises, 5);
    check("bit4_sclk_high", ts_sclk, 1);
    #2 Rst = 1'b0;
    #1;
    check("midrst_cs_n", ts_cs_n, 1);
    check("midrst_sclk", ts_sclk, 0);
    check("midrst_st", ST, 0);
    check("midrst_err", st_err, 0);
    check("midrst_valid", st_valid, 0);
    @(negedge Clk);
    Rst = 1'b1;

    // 99 = 1100011, four ones, parity 0.
    run_frame({1'b0, 7'd99, 1'b0}, 1'b1, gap, low, ve, vn);
    check("post_rst_delay", gap, 64);
    check("d99_valid", ve, 1);
    check("d99_st", ST, 99);
    check("d99_err", st_err, 0);

    repeat (4) @(posedge Clk);
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/smart_home_sensor_frontend.md
Name: smart_home_sensor_frontend

Overview:
- Producer side of the smart-home controller's sensor interface.
- Conditions raw door, window and fire-alarm contacts with a synchroniser plus debouncer.
- Polls a serial temperature sensor over a 3-wire read-only link and presents stable SFD/SRD/SW/SFA/ST levels that the controller FSM consumes directly.
- Guarantees the controller never sees contact bounce or a corrupted temperature word.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a debounced output changes (min 1).
- TEMP_W, 7: temperature word width; matches controller ST width.
- SCLK_HALF, 2: Clk cycles per ts_sclk half-period (min 1).
- TEMP_POLL, 64: idle Clk cycles between conversions (min 2).
- ST_RST, 0: ST value after reset.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous active-low reset
- raw_fd  in  1  front-door contact, asynchronous
- raw_rd  in  1  rear-door contact, asynchronous
- raw_w  in  1  window contact, asynchronous
- raw_fa  in  1  fire-alarm contact, asynchronous
- ts_sdo  in  1  temperature sensor serial data
- ts_cs_n  out  1  sensor chip select, active low
- ts_sclk  out  1  sensor serial clock
- SFD  out  1  debounced front door
- SRD  out  1  debounced rear door
- SW  out  1  debounced window
- SFA  out  1  debounced fire alarm
- ST  out  TEMP_W  last good temperature
- st_valid  out  1  one-cycle pulse when ST is updated
- st_err  out  1  last frame failed; sticky until the next good frame

Behaviour:
- Reset (Rst=0, async):
  - SFD/SRD/SW/SFA=0, ST=ST_RST, st_valid=0, st_err=0.
  - ts_cs_n=1, ts_sclk=0.
  - All counters 0, FSM=IDLE, synchroniser flops 0.
  - Reset mid-frame aborts immediately: cs_n=1, no ST update.
- Debounce, identical per channel:
  - 2-flop synchroniser, then counter.
  - Counter increments while the synchronised input differs from the output and clears when they match.
  - When the count reaches DEB_CYCLES, the output takes the input value and the counter clears.
  - Latency from a clean input edge to the output edge is 2+DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES cycles never reaches the output.
  - Channels are fully independent; simultaneous changes are each handled on their own.
- Serial frame, sensor to block, 9 bits:
  - Start bit (must be 0), then TEMP_W data bits MSB first, then an even-parity bit over the data bits.
  - Sensor changes ts_sdo on falling ts_sclk; the block samples ts_sdo on the Clk edge where ts_sclk rises.
- FSM:
  - IDLE: cs_n=1, sclk=0; poll counter counts to TEMP_POLL, then SELECT.
  - SELECT: cs_n=0 for SCLK_HALF cycles, then SHIFT.
  - SHIFT: per bit, sclk=0 for SCLK_HALF cycles, then sclk=1 for SCLK_HALF cycles; sample at the rising transition; 9 bits, bit counter 0..8.
    - Early abort: if bit 0 is sampled as 1, go to CHECK with the error flag set.
  - CHECK, 1 cycle: cs_n=1, sclk=0.
    - Good frame (start=0, parity even): ST<=data, st_valid=1 for this cycle, st_err<=0.
    - Otherwise: ST holds, st_err<=1, st_valid=0. Then IDLE with the poll counter cleared.
- Timing:
  - First conversion starts TEMP_POLL cycles after reset release.
  - Full frame occupies SCLK_HALF + 18*SCLK_HALF + 1 cycles.
  - ST changes only in CHECK, so it is stable for at least TEMP_POLL cycles between updates.
- ts_cs_n and ts_sclk are driven directly from flops (glitch-free).
- ST is never partially updated; the shift register is internal.

Test Plan:
- Reset, then release; hold raw_* = 0 and ts_sdo = 0 -> all outputs at reset values. ts_cs_n falls exactly 64 cycles after release. The all-zero frame (start 0, data 0, parity 0) is good -> ST=0, st_valid pulses once.
- raw_fd goes 0->1 cleanly -> SFD rises exactly 6 cycles later (2+4). A raw_rd pulse of 3 cycles -> SRD stays 0.
- Sensor returns data 7'd23 (0010111, four ones, parity 0) -> ST=23 in CHECK with a one-cycle st_valid pulse. ts_sclk shows 9 periods of 4 cycles each.
- Same data with parity bit 1 -> ST holds its previous value, st_err=1, no st_valid. A following good frame of 7'd30 clears st_err and gives ST=30.
- Start bit sampled as 1 -> frame aborted after the first bit (cs_n=1 within 1 cycle of CHECK), st_err=1, ST unchanged.
- Assert Rst low during SHIFT bit 4 -> cs_n=1 and ts_sclk=0 immediately. ST returns to ST_RST. After release, the next frame starts 64 cycles later.
